product_rr_arbiter: RTL

Round-robin arbiter that shares one registered product-typed output port `{x, y}` between N requesters. Each requester offers a `{x, y}` pair over a valid/ready handshake. The arbiter picks one requester, captures its pair into a single-entry output register, and presents that register downstream with its own valid/ready handshake. It sits between the product-producing combinational blocks and the consumer of the `O_x`/`O_y` product port.

---
 rtl/product_rr_arbiter_pkg.sv | 28 ++
 rtl/product_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/product_rr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/product_rr_arbiter_pkg.sv
// product_rr_arbiter_pkg
//   Shared definitions for the product round-robin arbiter and its picker:
//   default sizes, the {x, y} product typedef at default width, and width
//   helpers for the source index and the burst counter.
//   No ports (package).
package product_rr_arbiter_pkg;

  localparam int N_DEFAULT     = 4;
  localparam int W_DEFAULT     = 8;
  localparam int BURST_DEFAULT = 1;

  // Product pair as carried on the O_x/O_y port at the default width.
  typedef struct packed {
    logic [W_DEFAULT-1:0] x;
    logic [W_DEFAULT-1:0] y;
  } product_t;

  // Width of a requester index; never below one bit.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold a burst count in 0..BURST.
  function automatic int cnt_width(input int burst);
    return (burst > 0) ? $clog2(burst + 1) : 1;
  endfunction

endpackage

// File: rtl/product_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches the request vector upward
//   from last+1, wrapping at N-1, with `last` itself examined at the end.
//   Ports:
//     req     in   N     request vector
//     last    in   SW    index of the most recent winner
//     gnt     out  N     one-hot grant (all zero when nothing requests)
//     gnt_idx out  SW    index of the granted bit (0 when nothing requests)
module rr_pick
  import product_rr_arbiter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0]              req,
  input  logic [src_width(N)-1:0]   last,
  output logic [N-1:0]              gnt,
  output logic [src_width(N)-1:0]   gnt_idx
);

  localparam int SW = src_width(N);

  logic             found_s;
  logic [SW-1:0]    cand_s;

  // Wrap search: offset i=N lands back on `last`, so it has lowest priority.
  always_comb begin
    gnt     = {N{1'b0}};
    gnt_idx = {SW{1'b0}};
    found_s = 1'b0;
    cand_s  = {SW{1'b0}};
    for (int i = 1; i <= N; i++) begin
      cand_s = SW'((int'(last) + i) % N);
      if (!found_s && req[cand_s]) begin
        found_s      = 1'b1;
        gnt[cand_s]  = 1'b1;
        gnt_idx      = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/product_rr_arbiter.sv
// product_rr_arbiter
//   Round-robin arbiter sharing one registered {x, y} output between N
//   requesters, with optional bursts of up to BURST beats per requester.
//   Ports:
//     CLK          in   1      clock
//     ASYNCRESET   in   1      asynchronous active-high reset
//     I_valid      in   N      requester k offers a pair
//     I_ready      out  N      requester k's pair taken this cycle (0/1-hot)
//     I_x, I_y     in   N*W    requester k's fields at [k*W +: W]
//     O_valid      out  1      output register holds a pair
//     O_ready      in   1      consumer takes the pair
//     O_x, O_y     out  W      registered pair
//     O_src        out  SW     requester index of the registered pair
module product_rr_arbiter
  import product_rr_arbiter_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int BURST = BURST_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  input  logic [N-1:0]             I_valid,
  output logic [N-1:0]             I_ready,
  input  logic [N*W-1:0]           I_x,
  input  logic [N*W-1:0]           I_y,
  output logic                     O_valid,
  input  logic                     O_ready,
  output logic [W-1:0]             O_x,
  output logic [W-1:0]             O_y,
  output logic [src_width(N)-1:0]  O_src
);

  localparam int SW = src_width(N);
  localparam int CW = cnt_width(BURST);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(BURST - 1);
  localparam logic [SW-1:0] LAST_RESET = SW'(N - 1);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } pair_t;

  pair_t          pair_q, pair_d, sel_pair_s;
  logic           o_valid_q, o_valid_d;
  logic [SW-1:0]  src_q, src_d;
  logic [SW-1:0]  last_q, last_d;
  logic [CW-1:0]  burst_cnt_q, burst_cnt_d;

  logic           load_s;
  logic           cont_s;
  logic           xfer_s;
  logic [N-1:0]   pick_gnt_s;
  logic [SW-1:0]  pick_idx_s;
  logic [SW-1:0]  win_idx_s;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (I_valid),
    .last    (last_q),
    .gnt     (pick_gnt_s),
    .gnt_idx (pick_idx_s)
  );

  // Load/handshake decision and the grant toward the requesters.
  // I_ready is built from valids and state only, never from the data.
  always_comb begin
    load_s    = ~o_valid_q | O_ready;
    cont_s    = (burst_cnt_q != {CW{1'b0}}) && I_valid[last_q];
    xfer_s    = load_s & (|I_valid);
    win_idx_s = cont_s ? last_q : pick_idx_s;
    I_ready   = {N{1'b0}};
    if (xfer_s) begin
      if (cont_s) begin
        I_ready[last_q] = 1'b1;
      end else begin
        I_ready = pick_gnt_s;
      end
    end else begin
      I_ready = {N{1'b0}};
    end
  end

  // Data mux: the winner's {x, y} fields.
  always_comb begin
    sel_pair_s = '{x: {W{1'b0}}, y: {W{1'b0}}};
    for (int k = 0; k < N; k++) begin
      if (win_idx_s == SW'(k)) begin
        sel_pair_s.x = I_x[k*W +: W];
        sel_pair_s.y = I_y[k*W +: W];
      end else begin
        sel_pair_s = sel_pair_s;
      end
    end
  end

  // Next state: replace on transfer, empty on a load with no requester,
  // hold while stalled. A load opportunity without a transfer ends any burst.
  always_comb begin
    pair_d      = pair_q;
    o_valid_d   = o_valid_q;
    src_d       = src_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer_s) begin
      pair_d    = sel_pair_s;
      o_valid_d = 1'b1;
      src_d     = win_idx_s;
      last_d    = win_idx_s;
      if (cont_s) begin
        burst_cnt_d = burst_cnt_q - CW'(1);
      end else begin
        burst_cnt_d = CNT_RELOAD;
      end
    end else if (load_s) begin
      o_valid_d   = 1'b0;
      burst_cnt_d = {CW{1'b0}};
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // State registers; reset parks `last` at N-1 so requester 0 is searched first.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      pair_q      <= '{x: {W{1'b0}}, y: {W{1'b0}}};
      o_valid_q   <= 1'b0;
      src_q       <= {SW{1'b0}};
      last_q      <= LAST_RESET;
      burst_cnt_q <= {CW{1'b0}};
    end else begin
      pair_q      <= pair_d;
      o_valid_q   <= o_valid_d;
      src_q       <= src_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign O_valid = o_valid_q;
  assign O_x     = pair_q.x;
  assign O_y     = pair_q.y;
  assign O_src   = src_q;

endmodule
